// File: rtl/rp_bram_rd_sm_pkg.sv
// Package for the acquisition BRAM read sequencer.
// Holds the FSM state encoding and the output FIFO depth rule shared by the
// top and the FIFO sub-module.
package rp_bram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } rd_state_e;

   // The FIFO must hold every read that can still be in flight (RD_LAT) plus
   // two entries of slack so a stalled consumer never forces a drop.
   function automatic int fifo_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

endpackage

// File: rtl/rp_bram_rd_sm_if.sv
// Sample stream interface between the read sequencer and the readout path.
//   m_dat  : sample data
//   m_vld  : sample valid
//   m_last : last sample of the window (qualified by m_vld)
//   m_rdy  : consumer ready; a beat moves when m_vld & m_rdy
// master = sequencer side, slave = consumer side.
interface rp_bram_rd_sm_if #(
   parameter int DW = 14
) ();
   logic [DW-1:0] m_dat;
   logic          m_vld;
   logic          m_last;
   logic          m_rdy;

   modport master (output m_dat, output m_vld, output m_last, input m_rdy);
   modport slave  (input m_dat, input m_vld, input m_last, output m_rdy);
endinterface

// File: rtl/rp_bram_rd_sm_fifo.sv
// Small synchronous FIFO for the BRAM read sequencer.
// Output comes straight from the storage flops (no combinational path from
// push to dat_o/vld_o), so a sample pushed in cycle t is visible in t+1.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   flush_i           empties the FIFO (wins over push/pop)
//   push_i/push_dat_i write one entry (ignored when full)
//   pop_i             consume head entry (ignored when empty)
//   dat_o/vld_o       head entry and non-empty flag
module rp_bram_rd_fifo #(
   parameter int W     = 15,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] dat_o,
   output logic         vld_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign vld_o   = (cnt_q != '0);
   assign dat_o   = mem_q[rd_q];
   assign do_push = push_i & (cnt_q < CW'(DEPTH));
   assign do_pop  = pop_i & vld_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
            wr_q        <= ptr_nxt(wr_q);
         end
         if (do_pop) rd_q <= ptr_nxt(rd_q);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rp_bram_rd_sm.sv
// Read-side sequencer for the acquisition BRAM.
// After a capture it reads a window of min(len_i, 2^RSZ) samples starting
// min(pre_len_i, we_cnt_i) samples before the trigger pointer, wrapping the
// address modulo 2^RSZ, and streams them out through m_if. Reads are only
// issued while a slot in the output FIFO is guaranteed (credit counter), so
// backpressure never loses data.
// Ports:
//   adc_clk_i, adc_rst_i    clock, async active-high reset
//   start_i, abort_i        one-cycle control pulses
//   trig_ptr_i, pre_len_i,
//   we_cnt_i, len_i         window setup, sampled only in LOAD
//   rd_step_i               address step (only with RP_BRAM_RD_DEC_EN)
//   bram_addr_o, bram_en_o,
//   bram_dat_i              BRAM read port, data RD_LAT cycles after enable
//   m_if                    sample stream (master)
//   busy_o, done_o,
//   rd_cnt_o, state_o       status
// Build option: define RP_BRAM_RD_DEC_EN to add rd_step_i (decimating read,
// 0 treated as 1); otherwise the step is fixed at 1.
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | latch start address, window length and step
// RUN   | issuing BRAM reads while FIFO credit is available
// DRAIN | all reads issued, waiting for the last beat to be accepted
// DONE  | one-cycle done_o pulse
module rp_bram_rd_sm
   import rp_bram_pkg::*;
#(
   parameter int RSZ    = 14,
   parameter int DW     = 14,
   parameter int RD_LAT = 2
) (
   input  logic            adc_clk_i,
   input  logic            adc_rst_i,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [RSZ-1:0]  trig_ptr_i,
   input  logic [RSZ-1:0]  pre_len_i,
   input  logic [31:0]     we_cnt_i,
   input  logic [RSZ:0]    len_i,
`ifdef RP_BRAM_RD_DEC_EN
   input  logic [RSZ-1:0]  rd_step_i,
`endif
   output logic [RSZ-1:0]  bram_addr_o,
   output logic            bram_en_o,
   input  logic [DW-1:0]   bram_dat_i,
   rp_bram_rd_sm_if.master m_if,
   output logic            busy_o,
   output logic            done_o,
   output logic [RSZ:0]    rd_cnt_o,
   output logic [2:0]      state_o
);
   localparam int            DEPTH  = fifo_depth(RD_LAT);
   localparam int            CW     = $clog2(DEPTH + 1);
   localparam logic [RSZ:0]  N_FULL = {1'b1, {RSZ{1'b0}}};

   rd_state_e        state_q, state_d;
   logic [RSZ-1:0]   addr_q;
   logic [RSZ:0]     n_q, issue_cnt_q, rd_cnt_q;
   logic [CW-1:0]    credit_q;
   logic [RD_LAT-1:0] vsr_vld_q, vsr_last_q;

   logic             issue, issue_last, rd_last, pop, push;
   logic [RSZ-1:0]   pre_w, step_w;
   logic [RSZ:0]     n_load;
   logic [DW:0]      fifo_dat;
   logic             fifo_vld;

`ifdef RP_BRAM_RD_DEC_EN
   logic [RSZ-1:0]   step_q;
   assign step_w = step_q;
`else
   assign step_w = RSZ'(1);
`endif

   // we_cnt_i is wide; only a pre-trigger count below pre_len_i limits it.
   assign pre_w      = (we_cnt_i < 32'(pre_len_i)) ? we_cnt_i[RSZ-1:0] : pre_len_i;
   assign n_load     = (len_i > N_FULL) ? N_FULL : len_i;
   assign issue_last = ((issue_cnt_q + (RSZ+1)'(1)) == n_q);
   assign rd_last    = ((rd_cnt_q + (RSZ+1)'(1)) == n_q);
   assign pop        = fifo_vld & m_if.m_rdy;
   assign push       = vsr_vld_q[RD_LAT-1] & ~abort_i;

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_LOAD;
         ST_LOAD:  state_d = (n_load == '0) ? ST_DONE : ST_RUN;
         ST_RUN: begin
            issue = (credit_q < CW'(DEPTH));
            if (issue && issue_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (pop && rd_last) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Abort beats everything, including a coincident start in IDLE.
      if (abort_i) begin
         state_d = ST_IDLE;
         issue   = 1'b0;
      end
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         n_q         <= '0;
         issue_cnt_q <= '0;
         rd_cnt_q    <= '0;
         credit_q    <= '0;
         vsr_vld_q   <= '0;
         vsr_last_q  <= '0;
`ifdef RP_BRAM_RD_DEC_EN
         step_q      <= RSZ'(1);
`endif
      end else begin
         state_q <= state_d;

         if (state_q == ST_LOAD) begin
            addr_q      <= trig_ptr_i - pre_w;
            n_q         <= n_load;
            issue_cnt_q <= '0;
`ifdef RP_BRAM_RD_DEC_EN
            step_q      <= (rd_step_i == '0) ? RSZ'(1) : rd_step_i;
`endif
         end else if (issue) begin
            addr_q      <= addr_q + step_w;
            issue_cnt_q <= issue_cnt_q + (RSZ+1)'(1);
         end

         if (state_q == ST_LOAD) rd_cnt_q <= '0;
         else if (pop)           rd_cnt_q <= rd_cnt_q + (RSZ+1)'(1);

         // Valid/last ride alongside the BRAM pipeline so the returning word
         // is pushed exactly RD_LAT cycles after its enable.
         if (abort_i) begin
            vsr_vld_q  <= '0;
            vsr_last_q <= '0;
            credit_q   <= '0;
         end else begin
            vsr_vld_q[0]  <= issue;
            vsr_last_q[0] <= issue & issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
               vsr_vld_q[i]  <= vsr_vld_q[i-1];
               vsr_last_q[i] <= vsr_last_q[i-1];
            end
            // Credit = reads in flight + entries in the FIFO.
            case ({issue, pop})
               2'b10:   credit_q <= credit_q + CW'(1);
               2'b01:   credit_q <= credit_q - CW'(1);
               default: ;
            endcase
         end
      end
   end

   rp_bram_rd_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (adc_clk_i),
      .rst_i      (adc_rst_i),
      .flush_i    (abort_i),
      .push_i     (push),
      .push_dat_i ({vsr_last_q[RD_LAT-1], bram_dat_i}),
      .pop_i      (pop),
      .dat_o      (fifo_dat),
      .vld_o      (fifo_vld)
   );

   assign m_if.m_dat  = fifo_dat[DW-1:0];
   assign m_if.m_last = fifo_dat[DW];
   assign m_if.m_vld  = fifo_vld;

   assign bram_addr_o = addr_q;
   assign bram_en_o   = issue;
   assign busy_o      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done_o      = (state_q == ST_DONE) && !abort_i;
   assign rd_cnt_o    = rd_cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_rp_bram_rd_sm.sv
module tb_rp_bram_rd_sm;
   localparam int RSZ    = 14;
   localparam int DW     = 14;
   localparam int RD_LAT = 2;
   localparam logic [13:0] KEY = 14'h2A5A;

   logic        clk, rst;
   logic        start, abort;
   logic [13:0] trig_ptr, pre_len, rd_step;
   logic [31:0] we_cnt;
   logic [14:0] len;
   logic [13:0] bram_addr;
   logic        bram_en;
   logic [13:0] bram_dat;
   logic        busy, done;
   logic [14:0] rd_cnt;
   logic [2:0]  state;

   int n_chk = 0;
   int n_err = 0;

   rp_bram_rd_sm_if #(.DW(DW)) s_if ();

   rp_bram_rd_sm #(.RSZ(RSZ), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .adc_clk_i   (clk),
      .adc_rst_i   (rst),
      .start_i     (start),
      .abort_i     (abort),
      .trig_ptr_i  (trig_ptr),
      .pre_len_i   (pre_len),
      .we_cnt_i    (we_cnt),
      .len_i       (len),
`ifdef RP_BRAM_RD_DEC_EN
      .rd_step_i   (rd_step),
`endif
      .bram_addr_o (bram_addr),
      .bram_en_o   (bram_en),
      .bram_dat_i  (bram_dat),
      .m_if        (s_if.master),
      .busy_o      (busy),
      .done_o      (done),
      .rd_cnt_o    (rd_cnt),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: word = address ^ KEY, returned RD_LAT cycles after enable.
   logic [13:0] pipe [RD_LAT];
   always @(posedge clk) begin
      pipe[0] <= bram_en ? (bram_addr ^ KEY) : 14'h3FFF;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bram_dat = pipe[RD_LAT-1];

   typedef struct {
      logic [13:0] trig;
      logic [13:0] pre;
      logic [31:0] we;
      logic [14:0] len;
      int          rdy_pct;
      logic [13:0] step;
      logic [13:0] exp_first;
      int          exp_step;
      int          exp_n;
      bit          poke;
   } vec_t;

   vec_t vecs[$];
   bit   seen [16384];

   function automatic vec_t mk(input int trig, input int pre, input longint we, input int ln,
                               input int pct, input int step, input int first, input int estep,
                               input int n, input bit poke);
      vec_t v;
      v.trig = 14'(trig);  v.pre = 14'(pre);  v.we = 32'(we);  v.len = 15'(ln);
      v.rdy_pct = pct;     v.step = 14'(step); v.exp_first = 14'(first);
      v.exp_step = estep;  v.exp_n = n;        v.poke = poke;
      return v;
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_window(input vec_t v, input int idx);
      int cyc = 0, beats = 0, dones = 0, first_vld = -1, issues = 0, post = 0;
      int data_err = 0, last_err = 0, issue_err = 0, dup = 0, hold_err = 0, over = 0, st1 = -1;
      int budget;
      bit fin = 0, pend = 0;
      logic [13:0] h_dat, ea, ia;
      logic h_last;
      string tag;
      tag = $sformatf("v%0d", idx);
      budget = v.exp_n * 5 + 60;
      foreach (seen[i]) seen[i] = 1'b0;
      trig_ptr = v.trig; pre_len = v.pre; we_cnt = v.we; len = v.len; rd_step = v.step;
      while (cyc < budget && post < 3) begin
         start = (cyc == 0) || (v.poke && cyc == 8);
         s_if.m_rdy = ($urandom_range(0, 99) < v.rdy_pct);
         #1;
         if (cyc == 1) st1 = state;
         if (bram_en) begin
            ia = 14'(v.exp_first + issues * v.exp_step);
            if (bram_addr != ia) issue_err++;
            issues++;
         end
         if (issues - beats > RD_LAT + 2) over++;
         if (pend && (!s_if.m_vld || s_if.m_dat != h_dat || s_if.m_last != h_last)) hold_err++;
         if (s_if.m_vld) begin
            if (first_vld < 0) first_vld = cyc;
            if (s_if.m_rdy) begin
               ea = 14'(v.exp_first + beats * v.exp_step);
               if (s_if.m_dat != (ea ^ KEY)) data_err++;
               if (s_if.m_last != (beats + 1 == v.exp_n)) last_err++;
               if (seen[s_if.m_dat ^ KEY]) dup++;
               seen[s_if.m_dat ^ KEY] = 1'b1;
               beats++;
            end
         end
         pend   = s_if.m_vld && !s_if.m_rdy;
         h_dat  = s_if.m_dat;
         h_last = s_if.m_last;
         if (done) begin dones++; fin = 1; end
         if (fin) post++;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      #1;
      check({tag, " finished"}, fin, 1);
      check({tag, " load_state"}, st1, 1);
      check({tag, " first_vld_cycle"}, first_vld, RD_LAT + 3);
      check({tag, " beats"}, beats, v.exp_n);
      check({tag, " issues"}, issues, v.exp_n);
      check({tag, " issue_addr_errs"}, issue_err, 0);
      check({tag, " data_errs"}, data_err, 0);
      check({tag, " last_errs"}, last_err, 0);
      check({tag, " dup_samples"}, dup, 0);
      check({tag, " hold_errs"}, hold_err, 0);
      check({tag, " credit_overrun"}, over, 0);
      check({tag, " done_pulses"}, dones, 1);
      check({tag, " rd_cnt_final"}, rd_cnt, v.exp_n);
      check({tag, " idle_at_end"}, state, 0);
   endtask

   initial begin
      int done_cyc, dones, vld_seen, en_seen, bad, vld_pre;
      rst = 1'b1; start = 1'b0; abort = 1'b0; s_if.m_rdy = 1'b0;
      trig_ptr = '0; pre_len = '0; we_cnt = '0; len = '0; rd_step = 14'd1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {state, busy, done, s_if.m_vld, s_if.m_last, bram_en,
                              s_if.m_dat, bram_addr, rd_cnt}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", {state, busy, done, s_if.m_vld, bram_en}, 0);

      //              trig   pre    we            len    pct  step first  estep n      poke
      vecs.push_back(mk(100,   10,   1000,         20,    100, 1,   90,    1,    20,    1));
      vecs.push_back(mk(5,     10,   3,            8,     100, 1,   2,     1,    8,     0));
      vecs.push_back(mk(3,     8,    1000,         10,    100, 1,   16379, 1,    10,    0));
      vecs.push_back(mk(0,     0,    0,            16384, 100, 1,   0,     1,    16384, 0));
      vecs.push_back(mk(7,     100,  50,           20000, 100, 1,   16341, 1,    16384, 0));
      vecs.push_back(mk(1000,  200,  5000,         500,   30,  1,   800,   1,    500,   0));
      vecs.push_back(mk(0,     16383, 64'hFFFFFFFF, 1,    100, 1,   1,     1,    1,     0));
`ifdef RP_BRAM_RD_DEC_EN
      vecs.push_back(mk(0,     0,    0,            5,     100, 4,   0,     4,    5,     0));
      vecs.push_back(mk(50,    2,    9,            6,     100, 0,   48,    1,    6,     0));
`endif
      for (int i = 0; i < vecs.size(); i++) run_window(vecs[i], i);

      // len = 0: done two cycles after start, no data.
      trig_ptr = 14'd40; pre_len = 14'd0; we_cnt = 0; len = 15'd0; s_if.m_rdy = 1'b1;
      done_cyc = -1; dones = 0; vld_seen = 0; en_seen = 0;
      for (int c = 0; c < 8; c++) begin
         start = (c == 0);
         #1;
         if (done) begin dones++; if (done_cyc < 0) done_cyc = c; end
         if (s_if.m_vld) vld_seen++;
         if (bram_en) en_seen++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("len0 done_cycle", done_cyc, 2);
      check("len0 done_pulses", dones, 1);
      check("len0 no_vld", vld_seen, 0);
      check("len0 no_issue", en_seen, 0);

      // Abort mid-RUN: IDLE next cycle, stream stops, no done.
      trig_ptr = 14'd200; pre_len = 14'd0; we_cnt = 0; len = 15'd100;
      vld_pre = 0; vld_seen = 0; en_seen = 0; dones = 0;
      for (int c = 0; c < 26; c++) begin
         start = (c == 0);
         abort = (c == 10);
         #1;
         if (c < 10 && s_if.m_vld) vld_pre++;
         if (c == 10) check("abort en_gated", bram_en, 0);
         if (c == 11) check("abort idle_next", {state, busy, s_if.m_vld}, 0);
         if (c > 10 && s_if.m_vld) vld_seen++;
         if (c >= 10 && bram_en) en_seen++;
         if (done) dones++;
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0;
      check("abort stream_was_running", vld_pre > 0, 1);
      check("abort no_vld_after", vld_seen, 0);
      check("abort no_issue_after", en_seen, 0);
      check("abort no_done", dones, 0);
      run_window(mk(300, 5, 5, 12, 100, 1, 295, 1, 12, 0), 90);

      // Start and abort together in IDLE: abort wins.
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         start = (c == 0);
         abort = (c == 0);
         #1;
         if (c > 0 && (state != 3'd0 || busy)) bad++;
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0;
      check("start_abort stay_idle", bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
